// File: rtl/waveform_shaper.sv
// Streaming waveform converter: re-shapes each frame of samples into sine, triangle,
// square or FM, with frame-aligned mode switching and a registered valid/ready output.
module waveform_shaper #(
    parameter int DATA_W      = 8,
    parameter int FRAME_LEN   = 256,
    parameter int FM_MAX_STEP = 20,
    parameter int FM_MIN_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        sw,
    input  logic              restart,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int POS_W = $clog2(FM_MAX_STEP + 1);

    localparam logic [3:0] MODE_SINE = 4'b0001;
    localparam logic [3:0] MODE_TRI  = 4'b0010;
    localparam logic [3:0] MODE_SQR  = 4'b0100;
    localparam logic [3:0] MODE_FM   = 4'b1000;

    logic [IDX_W-1:0]  idx;
    logic [3:0]        mode_q;
    logic [3:0]        mode_eff;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_eff;
    logic [POS_W-1:0]  pos_next;
    logic              fm_bit;
    logic              fm_bit_eff;
    logic              fm_bit_next;
    logic              accept;
    logic              frame_start;
    logic [IDX_W-1:0]  tri_raw;
    logic [DATA_W-1:0] tri_val;
    logic [DATA_W-1:0] result;
    logic [31:0]       fm_prod;
    logic [31:0]       fm_step;

    assign frame_start = (idx == '0);
    assign s_ready     = !restart && (!m_valid || m_ready);
    assign accept      = s_valid && s_ready;

    // Frame start uses the live switch and a fresh FM phase; mid-frame uses latched state.
    assign mode_eff   = frame_start ? sw : mode_q;
    assign pos_eff    = frame_start ? '0 : pos;
    assign fm_bit_eff = frame_start ? 1'b0 : fm_bit;

    // Falling half: 2*(FRAME_LEN-1-idx) equals the low bits of ~idx shifted left.
    assign tri_raw = idx[IDX_W-1] ? {~idx[IDX_W-2:0], 1'b0} : {idx[IDX_W-2:0], 1'b0};

    generate
        if (DATA_W > IDX_W) begin : g_tri_wide
            assign tri_val = {tri_raw, {(DATA_W-IDX_W){1'b0}}};
        end else begin : g_tri_narrow
            assign tri_val = tri_raw[IDX_W-1 -: DATA_W];
        end
    endgenerate

    assign fm_prod = 32'(s_data) * 32'(FM_MAX_STEP - FM_MIN_STEP);
    assign fm_step = 32'(FM_MAX_STEP) - fm_prod / 32'((2 ** DATA_W) - 1);

    always_comb begin
        pos_next    = pos_eff + POS_W'(1);
        fm_bit_next = fm_bit_eff;
        if (32'(pos_eff) + 32'd1 >= fm_step) begin
            pos_next    = '0;
            fm_bit_next = !fm_bit_eff;
        end
    end

    always_comb begin
        result = '0;
        case (mode_eff)
            MODE_SINE: result = s_data;
            MODE_TRI:  result = tri_val;
            MODE_SQR:  result = s_data[DATA_W-1] ? '1 : '0;
            MODE_FM:   result = fm_bit_next ? '1 : '0;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            mode_q  <= '0;
            pos     <= '0;
            fm_bit  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            if (restart) begin
                idx    <= '0;
                pos    <= '0;
                fm_bit <= 1'b0;
            end else if (accept) begin
                idx    <= idx + IDX_W'(1);
                pos    <= pos_next;
                fm_bit <= fm_bit_next;
                if (frame_start) begin
                    mode_q <= sw;
                end
            end

            // Restart leaves a pending output beat untouched.
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= result;
                m_last  <= &idx;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_waveform_shaper.sv
// Randomized scoreboard bench for waveform_shaper: driver pushes model results,
// monitor pops them on output handshakes and also checks stall stability.
module tb_waveform_shaper;

    localparam int DW   = 8;
    localparam int FL   = 256;
    localparam int MAXS = 20;
    localparam int MINS = 1;
    localparam int FS   = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sw = 4'b0;
    logic          restart = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    waveform_shaper #(
        .DATA_W(DW), .FRAME_LEN(FL), .FM_MAX_STEP(MAXS), .FM_MIN_STEP(MINS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .restart(restart),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int l;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    passed = 0;
    bit    in_reset = 1'b1;

    // Reference model state, in plain integers
    int    r_idx = 0;
    int    r_mode = 0;
    int    r_pos = 0;
    int    r_bit = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic beat_t model(input int s, input int d);
        beat_t b;
        int    step;
        if (r_idx == 0) begin
            r_mode = s;
            r_pos  = 0;
            r_bit  = 0;
        end
        case (r_mode)
            1: b.d = d;
            2: b.d = (r_idx < FL / 2) ? 2 * r_idx : 2 * (FL - 1 - r_idx);
            4: b.d = (d >= 128) ? FS : 0;
            8: begin
                step = MAXS - (d * (MAXS - MINS)) / FS;
                if (r_pos + 1 >= step) begin
                    r_bit = 1 - r_bit;
                    r_pos = 0;
                end else begin
                    r_pos = r_pos + 1;
                end
                b.d = r_bit ? FS : 0;
            end
            default: b.d = 0;
        endcase
        b.l   = (r_idx == FL - 1) ? 1 : 0;
        r_idx = (r_idx + 1) % FL;
        return b;
    endfunction

    task automatic drive(input int swv, input int d, input bit v, input bit rs,
                         input int rdy_pct, output bit acc);
        beat_t b;
        int    exp_rdy;
        @(negedge clk);
        sw      = swv[3:0];
        s_data  = d[DW-1:0];
        s_valid = v;
        restart = rs;
        m_ready = ($urandom_range(99) < rdy_pct);
        #1;
        exp_rdy = (!rs && (q.size() == 0 || m_ready)) ? 1 : 0;
        check("s_ready", int'(s_ready), exp_rdy);
        acc = v && (exp_rdy == 1);
        if (acc) b = model(swv, d);
        if (rs) begin
            r_idx = 0;
            r_pos = 0;
            r_bit = 0;
        end
        @(posedge clk);
        if (acc) q.push_back(b);
    endtask

    task automatic send(input int swv, input int d, input int rdy_pct);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 100) begin
            drive(swv, d, 1'b1, 1'b0, rdy_pct, acc);
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    // Monitor: samples just before the rising edge
    beat_t mb;
    bit    stall_pend = 1'b0;
    int    held_d;
    int    held_l;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (in_reset) begin
                stall_pend = 1'b0;
            end else begin
                check("m_valid", int'(m_valid), (q.size() != 0) ? 1 : 0);
                if (stall_pend) begin
                    check("stall_data", int'(m_data), held_d);
                    check("stall_last", int'(m_last), held_l);
                end
                stall_pend = m_valid && !m_ready;
                held_d     = int'(m_data);
                held_l     = int'(m_last);
                if (m_valid && m_ready && q.size() > 0) begin
                    mb = q.pop_front();
                    check("m_data", int'(m_data), mb.d);
                    check("m_last", int'(m_last), mb.l);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int mode_pick;

        repeat (3) @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        for (int i = 0; i < FL; i++) send(1, i, 100);
        for (int i = 0; i < FL; i++) send(2, $urandom_range(255), 100);
        send(4, 127, 100); send(4, 128, 100); send(4, 0, 100); send(4, 255, 100);
        for (int i = 4; i < FL; i++) send(4, $urandom_range(255), 100);
        for (int i = 0; i < FL; i++) send(3, $urandom_range(255), 100);
        for (int i = 0; i < FL; i++) send(8, 0, 100);
        for (int i = 0; i < FL; i++) send(8, 255, 100);
        for (int i = 0; i < FL; i++) send(8, $urandom_range(255), 70);

        for (int i = 0; i < FL; i++) send((i < 100) ? 1 : 4, $urandom_range(255), 100);
        for (int i = 0; i < FL; i++) send(4, $urandom_range(255), 100);

        for (int f = 0; f < 2; f++) begin
            mode_pick = 1 << $urandom_range(3);
            for (int i = 0; i < FL; i++) send(mode_pick, $urandom_range(255), 40);
        end

        for (int i = 0; i < 50; i++) send(1, $urandom_range(255), 60);
        drive(2, 77, 1'b1, 1'b1, 50, acc);
        check("restart_blocks", int'(acc), 0);
        for (int i = 0; i < FL + 10; i++) send(2, $urandom_range(255), 60);

        // Reset while a beat is stalled at the output
        drive(1, 0, 1'b0, 1'b0, 100, acc);
        drive(1, 0, 1'b0, 1'b0, 100, acc);
        drive(1, 85, 1'b1, 1'b0, 0, acc);
        drive(1, 0, 1'b0, 1'b0, 0, acc);
        drive(1, 0, 1'b0, 1'b0, 0, acc);
        @(negedge clk);
        #2;
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data", int'(m_data), 0);
        check("midrst_m_last", int'(m_last), 0);
        q.delete();
        r_idx  = 0;
        r_mode = 0;
        r_pos  = 0;
        r_bit  = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        for (int i = 0; i < FL; i++) send(8, $urandom_range(255), 80);

        for (int n = 0; n < 20 && q.size() != 0; n++) drive(0, 0, 1'b0, 1'b0, 100, acc);
        check("drain_empty", q.size(), 0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
